// File: rtl/vector_reduce_sum_16_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_reduce_sum_16_if
// Description : Bus bundle between the element-wise vector add stage and the
//               16-to-1 reduction tree.
//               master : upstream producer plus result consumer
//                        (drives enable, inReady and S0..S15;
//                         receives outReady, SUM and earlyOutReady)
//               slave  : the reduction tree itself
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_reduce_sum_16_if #(
   parameter int IN_WIDTH = 15
);
   logic                       enable;
   logic                       inReady;
   logic signed [IN_WIDTH-1:0] S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7;
   logic signed [IN_WIDTH-1:0] S8,  S9,  S10, S11, S12, S13, S14, S15;
   logic                       outReady;
   logic signed [IN_WIDTH+3:0] SUM;
   logic                       earlyOutReady;

   modport master (
      output enable, inReady,
      output S0, S1, S2, S3, S4, S5, S6, S7,
      output S8, S9, S10, S11, S12, S13, S14, S15,
      input  outReady, SUM, earlyOutReady
   );

   modport slave (
      input  enable, inReady,
      input  S0, S1, S2, S3, S4, S5, S6, S7,
      input  S8, S9, S10, S11, S12, S13, S14, S15,
      output outReady, SUM, earlyOutReady
   );
endinterface
`default_nettype wire

// File: rtl/vector_reduce_sum_16.sv
`default_nettype none
// ============================================================================
// Module      : vector_reduce_sum_16
// Description : Fully pipelined 16-to-1 signed adder tree with four registered
//               levels (16->8->4->2->1). Each level grows by one bit, so the
//               total is exact for every input. A valid chain v1..v4 runs
//               alongside; data registers only load when their incoming valid
//               bit is set, so SUM holds the last valid result.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-low reset
//               bus    - vector_reduce_sum_16_if.slave
//                        (enable, inReady, S0..S15 in;
//                         outReady, SUM, earlyOutReady out)
// Config      : VECTOR_REDUCE_EARLY_READY_EN - when defined, earlyOutReady
//               follows v3 (one enabled cycle ahead of outReady); otherwise
//               it is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_reduce_sum_16 #(
   parameter int IN_WIDTH = 15
) (
   input  wire logic              clk,
   input  wire logic              reset,
   vector_reduce_sum_16_if.slave  bus
);

   logic signed [IN_WIDTH-1:0] lane [16];

   logic signed [IN_WIDTH:0]   l1_d [8];
   logic signed [IN_WIDTH:0]   l1_q [8];
   logic signed [IN_WIDTH+1:0] l2_d [4];
   logic signed [IN_WIDTH+1:0] l2_q [4];
   logic signed [IN_WIDTH+2:0] l3_d [2];
   logic signed [IN_WIDTH+2:0] l3_q [2];
   logic signed [IN_WIDTH+3:0] sum_d;
   logic signed [IN_WIDTH+3:0] sum_q;
   // v_q[0] = v1 ... v_q[3] = v4
   logic [3:0]                 v_d;
   logic [3:0]                 v_q;

   assign lane[0]  = bus.S0;
   assign lane[1]  = bus.S1;
   assign lane[2]  = bus.S2;
   assign lane[3]  = bus.S3;
   assign lane[4]  = bus.S4;
   assign lane[5]  = bus.S5;
   assign lane[6]  = bus.S6;
   assign lane[7]  = bus.S7;
   assign lane[8]  = bus.S8;
   assign lane[9]  = bus.S9;
   assign lane[10] = bus.S10;
   assign lane[11] = bus.S11;
   assign lane[12] = bus.S12;
   assign lane[13] = bus.S13;
   assign lane[14] = bus.S14;
   assign lane[15] = bus.S15;

   // Operands are sign-extended by one bit explicitly before each add so the
   // carry out of every level is preserved.
   always_comb begin
      v_d = v_q;
      if (bus.enable) begin
         v_d = {v_q[2:0], bus.inReady};
      end

      for (int i = 0; i < 8; i++) begin
         l1_d[i] = l1_q[i];
         if (bus.enable && bus.inReady) begin
            l1_d[i] = {lane[2*i][IN_WIDTH-1],   lane[2*i]}
                    + {lane[2*i+1][IN_WIDTH-1], lane[2*i+1]};
         end
      end

      for (int i = 0; i < 4; i++) begin
         l2_d[i] = l2_q[i];
         if (bus.enable && v_q[0]) begin
            l2_d[i] = {l1_q[2*i][IN_WIDTH],   l1_q[2*i]}
                    + {l1_q[2*i+1][IN_WIDTH], l1_q[2*i+1]};
         end
      end

      for (int i = 0; i < 2; i++) begin
         l3_d[i] = l3_q[i];
         if (bus.enable && v_q[1]) begin
            l3_d[i] = {l2_q[2*i][IN_WIDTH+1],   l2_q[2*i]}
                    + {l2_q[2*i+1][IN_WIDTH+1], l2_q[2*i+1]};
         end
      end

      sum_d = sum_q;
      if (bus.enable && v_q[2]) begin
         sum_d = {l3_q[0][IN_WIDTH+2], l3_q[0]}
               + {l3_q[1][IN_WIDTH+2], l3_q[1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) l1_q[i] <= '0;
         for (int i = 0; i < 4; i++) l2_q[i] <= '0;
         for (int i = 0; i < 2; i++) l3_q[i] <= '0;
         sum_q <= '0;
         v_q   <= '0;
      end else begin
         for (int i = 0; i < 8; i++) l1_q[i] <= l1_d[i];
         for (int i = 0; i < 4; i++) l2_q[i] <= l2_d[i];
         for (int i = 0; i < 2; i++) l3_q[i] <= l3_d[i];
         sum_q <= sum_d;
         v_q   <= v_d;
      end
   end

   assign bus.SUM      = sum_q;
   assign bus.outReady = v_q[3];

`ifdef VECTOR_REDUCE_EARLY_READY_EN
   assign bus.earlyOutReady = v_q[2];
`else
   assign bus.earlyOutReady = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_reduce_sum_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_reduce_sum_16
// Description : Directed self-checking bench for vector_reduce_sum_16 with
//               IN_WIDTH = 15. Expected values are hand-computed constants.
//               Honours VECTOR_REDUCE_EARLY_READY_EN for earlyOutReady checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_reduce_sum_16;

   localparam int IN_WIDTH = 15;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic signed [IN_WIDTH-1:0] tl [16];

   vector_reduce_sum_16_if #(.IN_WIDTH(IN_WIDTH)) bus ();

   vector_reduce_sum_16 #(.IN_WIDTH(IN_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.S0  = tl[0];
   assign bus.S1  = tl[1];
   assign bus.S2  = tl[2];
   assign bus.S3  = tl[3];
   assign bus.S4  = tl[4];
   assign bus.S5  = tl[5];
   assign bus.S6  = tl[6];
   assign bus.S7  = tl[7];
   assign bus.S8  = tl[8];
   assign bus.S9  = tl[9];
   assign bus.S10 = tl[10];
   assign bus.S11 = tl[11];
   assign bus.S12 = tl[12];
   assign bus.S13 = tl[13];
   assign bus.S14 = tl[14];
   assign bus.S15 = tl[15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_sum(input string tag, input logic signed [31:0] exp);
      chk(tag, $signed(bus.SUM), exp);
   endtask

   task automatic chk_rdy(input string tag, input logic exp);
      chk(tag, {31'd0, bus.outReady}, {31'd0, exp});
   endtask

   // earlyOutReady is v3 when the feature is built in, constant 0 otherwise
   task automatic chk_early(input string tag, input logic exp_when_en);
`ifdef VECTOR_REDUCE_EARLY_READY_EN
      chk(tag, {31'd0, bus.earlyOutReady}, {31'd0, exp_when_en});
`else
      chk(tag, {31'd0, bus.earlyOutReady}, {31'd0, exp_when_en & 1'b0});
`endif
   endtask

   task automatic set_all(input int v);
      for (int k = 0; k < 16; k++) tl[k] = IN_WIDTH'(v);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b0;
      bus.enable  = 1'b0;
      bus.inReady = 1'b0;
      set_all(0);

      // ---------------- reset state ----------------
      tick();
      tick();
      chk_sum("reset_sum", 0);
      chk_rdy("reset_rdy", 1'b0);
      chk_early("reset_early", 1'b0);
      reset      = 1'b1;
      bus.enable = 1'b1;
      tick();

      // ---------------- basic: all lanes 1 ----------------
      set_all(1);
      bus.inReady = 1'b1;
      tick();                               // E0
      bus.inReady = 1'b0;
      tick();                               // E1
      chk_rdy("basic_rdy_e1", 1'b0);
      tick();                               // E2
      chk_rdy("basic_rdy_e2", 1'b0);
      chk_early("basic_early_e2", 1'b1);
      tick();                               // E3
      chk_sum("basic_sum_e3", 16);
      chk_rdy("basic_rdy_e3", 1'b1);
      chk_early("basic_early_e3", 1'b0);
      tick();                               // E4
      chk_rdy("basic_rdy_e4", 1'b0);
      chk_sum("basic_sum_hold", 16);

      // ---------------- extremes, back to back ----------------
      set_all(-16384);
      bus.inReady = 1'b1;
      tick();
      set_all(16383);
      tick();
      for (int k = 0; k < 16; k++) tl[k] = (k % 2 == 0) ? 15'sd16383 : -15'sd16384;
      tick();
      bus.inReady = 1'b0;
      tick();
      chk_sum("ext_min_sum", -262144);
      chk_rdy("ext_min_rdy", 1'b1);
      tick();
      chk_sum("ext_max_sum", 262128);
      chk_rdy("ext_max_rdy", 1'b1);
      tick();
      chk_sum("ext_alt_sum", -8);
      chk_rdy("ext_alt_rdy", 1'b1);
      tick();
      chk_rdy("ext_after_rdy", 1'b0);
      chk_sum("ext_after_sum", -8);

      // ---------------- back-to-back 5 vectors, lane k = k*i ----------------
      for (int i = 1; i <= 5; i++) begin
         for (int k = 0; k < 16; k++) tl[k] = IN_WIDTH'(k * i);
         bus.inReady = 1'b1;
         tick();                            // tick number i
         if (i >= 3) chk_early("b2b_early_in", 1'b1);
         if (i >= 4) begin
            chk_sum("b2b_sum_in", 120 * (i - 3));
            chk_rdy("b2b_rdy_in", 1'b1);
         end
      end
      bus.inReady = 1'b0;
      for (int j = 6; j <= 8; j++) begin
         tick();
         chk_sum("b2b_sum_tail", 120 * (j - 3));
         chk_rdy("b2b_rdy_tail", 1'b1);
         chk_early("b2b_early_tail", j <= 7);
      end
      tick();
      chk_rdy("b2b_rdy_end", 1'b0);
      chk_sum("b2b_sum_end", 600);

      // ---------------- stall with vector in L2 ----------------
      set_all(2);
      bus.inReady = 1'b1;
      tick();                               // E0: in L1
      bus.inReady = 1'b0;
      tick();                               // E1: in L2
      bus.enable = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         chk_rdy("stall_rdy_frozen", 1'b0);
         chk_sum("stall_sum_frozen", 600);
      end
      bus.enable = 1'b1;
      tick();                               // E2
      chk_rdy("stall_rdy_e2", 1'b0);
      chk_early("stall_early_e2", 1'b1);
      tick();                               // E3
      chk_sum("stall_sum_e3", 32);
      chk_rdy("stall_rdy_e3", 1'b1);
      // stall while outReady is high: it must stay high
      bus.enable = 1'b0;
      tick();
      tick();
      chk_rdy("stall_rdy_high_frozen", 1'b1);
      chk_sum("stall_sum_high_frozen", 32);
      bus.enable = 1'b1;
      tick();
      chk_rdy("stall_rdy_after", 1'b0);

      // ---------------- reset mid-flight ----------------
      set_all(3);
      bus.inReady = 1'b1;
      tick();
      tick();
      tick();                               // three vectors in flight
      bus.inReady = 1'b0;
      #2;
      reset = 1'b0;                         // between edges
      #1;
      chk_sum("rst_async_sum", 0);
      chk_rdy("rst_async_rdy", 1'b0);
      chk_early("rst_async_early", 1'b0);
      tick();
      tick();
      reset = 1'b1;
      for (int s = 0; s < 5; s++) begin
         tick();
         chk_rdy("rst_no_ghost_rdy", 1'b0);
         chk_sum("rst_no_ghost_sum", 0);
      end
      set_all(-1);
      bus.inReady = 1'b1;
      tick();                               // E0
      bus.inReady = 1'b0;
      tick();
      tick();
      chk_rdy("rst_new_rdy_e2", 1'b0);
      tick();                               // E3
      chk_rdy("rst_new_rdy_e3", 1'b1);
      chk_sum("rst_new_sum_e3", -16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vector_reduce_sum_16.md
# vector_reduce_sum_16

Pipelined 16-to-1 signed reduction adder tree that consumes the 16-lane sum vector produced by the element-wise vector adder stage and emits the scalar total of all lanes. It sits directly downstream of the vector add stage in the linear-algebra layer-0 datapath, so that dot-product and norm blocks can be composed from vector add, multiply and reduce stages. The block is fully pipelined: it accepts one vector per clock, and every accepted vector yields exactly one `outReady`-qualified result.

## Interface
Parameters:
- `IN_WIDTH`, default 15: width of each signed input lane. This matches the upstream adder output width (14 + 1).

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. It asserts asynchronously and is released synchronously by the system.
- `enable`  input  1  global clock enable. When low, all state is frozen.
- `inReady`  input  1  input vector valid, sampled on the rising edge.
- `S0`…`S15`  input  IN_WIDTH each  signed lanes to be reduced.
- `outReady`  output  1  `SUM` valid strobe.
- `SUM`  output  IN_WIDTH+4  signed total of the 16 lanes.
- `earlyOutReady`  output  1  asserts one cycle ahead of `outReady`. Present only when the configuration macro is defined; otherwise driven 0.

## Operation
- Binary adder tree with 4 registered levels: 16→8 (L1), 8→4 (L2), 4→2 (L3), 2→1 (L4, the `SUM` register).
- Width rule: L1 lanes are IN_WIDTH+1 bits, L2 IN_WIDTH+2, L3 IN_WIDTH+3, L4 IN_WIDTH+4.
  - Every operand is sign-extended before each addition.
  - No saturation and no truncation: the result is exact for all inputs.
- Valid shift chain `v1..v4` runs in parallel with the data path.
  - `v1` loads `inReady`, and `vN` loads `v(N-1)`.
  - `outReady` is `v4`.
- A data register at level N loads only when `enable` is 1 and its incoming valid bit is 1. Otherwise it holds.
  - Consequence: `SUM` holds the last valid result indefinitely.
- A valid-bit register loads whenever `enable` is 1. Bubbles (`inReady` = 0) propagate as 0.
- There is no backpressure. The consumer must accept every result.
- Reset: all data registers, `v1..v4`, `SUM`, `outReady` and `earlyOutReady` go to 0 asynchronously while `reset` = 0. In-flight vectors are discarded.

## Timing
- Latency: a vector sampled with `inReady` = 1 and `enable` = 1 at edge E0 appears on `SUM` with `outReady` = 1 after edge E3. This counts enabled edges only.
- Throughput: one vector per enabled cycle.
  - N consecutive accepted vectors produce N consecutive `outReady` cycles, in order.
- `outReady` is high for one enabled cycle per accepted vector.
- Stall with `enable` = 0: every register holds, including `outReady`.
  - A high `outReady` therefore stays high across the stall.
  - Consumers must qualify `outReady` with `enable`.
- Coincident `inReady` and `outReady`: no interaction; both proceed.
- `reset` asserted mid-stream: outputs reach 0 without waiting for a clock edge.
  - After release, the first `outReady` appears only for vectors accepted after release.

## Configuration
- Macro: `VECTOR_REDUCE_EARLY_READY_EN`.
- Defined: `earlyOutReady` = `v3`. It is high exactly one enabled cycle before the matching `outReady`, and is frozen by `enable` like every other register.
- Undefined: `earlyOutReady` is tied to constant 0 and no extra logic is generated. `SUM` and `outReady` are unchanged.

## Test plan
- Basic reduction: IN_WIDTH = 15, all lanes = 1, single `inReady` pulse at E0.
  - Required: `SUM` = 16 and `outReady` = 1 after E3, `outReady` = 0 after E4, `SUM` still 16.
- Extremes:
  - All lanes = −16384 gives `SUM` = −262144.
  - All lanes = 16383 gives `SUM` = 262128.
  - Lanes alternating +16383 / −16384 gives `SUM` = −8.
- Back-to-back: 5 consecutive vectors with lane k = k·i for i = 1..5.
  - Required: 5 consecutive `outReady` cycles with `SUM` = 120, 240, 360, 480, 600.
- Stall: drop `enable` for 3 cycles while a vector sits in L2.
  - Required: result appears exactly 3 cycles later than nominal, with the correct value.
  - Required: `outReady` stays frozen during the stall.
- Reset mid-flight: assert `reset` low asynchronously, between edges, while 3 vectors are in flight.
  - Required: `SUM` = 0 and `outReady` = 0 immediately, and no `outReady` after release until a new vector has been accepted and 4 enabled edges have passed.
- Macro: build with and without `VECTOR_REDUCE_EARLY_READY_EN`.
  - Required when defined: `earlyOutReady` leads `outReady` by exactly 1 cycle for every vector.
  - Required when undefined: `earlyOutReady` is constant 0.
